alu_muldiv_unit: RTL and testbench



---
 rtl/alu_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU: registered single-cycle logic/arith/compare ops plus iterative
// shift-add multiply and restoring divide writing the architectural HI/LO pair.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_MULTU= 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t state, next_state;

    logic               accept, is_muldiv, signed_op, div_op, sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic               add_ovf;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_carry, sc_ovf;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH-1:0]   acc_hi, acc_lo, m_reg, a_raw;
    logic [CNT_W-1:0]   count;
    logic               is_div, neg_lo, neg_hi, div_zero;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shifted;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept    = in_valid && in_ready;
    assign is_muldiv = (alu_op == OP_MULT) || (alu_op == OP_MULTU) ||
                       (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    assign signed_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign div_op    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);

    // SUB reuses the adder as A + ~B + 1 so carry_out reads as not-borrow
    assign sub_op  = (alu_op == OP_SUB);
    assign b_eff   = sub_op ? ~B : B;
    assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        case (alu_op)
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_ADD, OP_SUB: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_carry  = sum_ext[WIDTH];
                sc_ovf    = add_ovf;
            end
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MFHI: sc_result = hi_out;
            OP_MFLO: sc_result = lo_out;
            default: sc_result = '0;
        endcase
    end

    // Signed mul/div run on magnitudes; signs are reapplied in FIX
    assign a_neg = signed_op && A[WIDTH-1];
    assign b_neg = signed_op && B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    assign mul_sum     = {1'b0, acc_hi} + {1'b0, m_reg & {WIDTH{acc_lo[0]}}};
    assign div_shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge      = div_shifted >= {1'b0, m_reg};
    assign div_diff    = div_shifted[WIDTH-1:0] - m_reg;

    assign prod_raw = {acc_hi, acc_lo};
    assign prod_fix = neg_lo ? -prod_raw : prod_raw;

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fix_lo = div_zero ? '1 : (neg_lo ? -acc_lo : acc_lo);
            fix_hi = div_zero ? a_raw : (neg_hi ? -acc_hi : acc_hi);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && is_muldiv) next_state = BUSY;
            BUSY:    if (count == CNT_W'(1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            hi_out    <= '0;
            lo_out    <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            m_reg     <= '0;
            a_raw     <= '0;
            count     <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_muldiv) begin
                        acc_hi   <= '0;
                        acc_lo   <= a_mag;
                        m_reg    <= b_mag;
                        a_raw    <= A;
                        count    <= CNT_W'(WIDTH);
                        is_div   <= div_op;
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= div_op ? a_neg : (a_neg ^ b_neg);
                        div_zero <= div_op && (B == '0);
                    end else if (accept) begin
                        alu_out   <= sc_result;
                        carry_out <= sc_carry;
                        overflow  <= sc_ovf;
                        zero      <= (sc_result == '0);
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    count <= count - CNT_W'(1);
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shifted[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_out    <= fix_hi;
                    lo_out    <= fix_lo;
                    alu_out   <= fix_lo;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= (fix_lo == '0);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: single-cycle vector table plus
// hand-written multi-cycle sequences (latency, back-to-back, hold, reset abort).
module tb_alu_muldiv_unit;

    localparam int W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_MULTU= 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] A, B;
    logic         out_valid;
    logic [W-1:0] alu_out;
    logic         carry_out, overflow, zero;
    logic [W-1:0] hi_out, lo_out;

    int checks = 0;
    int fails  = 0;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .A(A), .B(B), .out_valid(out_valid), .alu_out(alu_out),
        .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic         exp_carry;
        logic         exp_ovf;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[10];

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_op   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
    endtask

    task automatic check_output(input string name, input logic [W-1:0] exp_out,
                                input logic exp_c, input logic exp_o, input logic exp_z);
        check_val({name, " out_valid"}, W'(out_valid), W'(1'b1));
        check_val({name, " alu_out"},   alu_out, exp_out);
        check_val({name, " carry"},     W'(carry_out), W'(exp_c));
        check_val({name, " overflow"},  W'(overflow), W'(exp_o));
        check_val({name, " zero"},      W'(zero), W'(exp_z));
    endtask

    // Issues one mul/div and returns at the negedge where out_valid is seen
    task automatic run_muldiv(input string name, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                              input logic [W-1:0] exp_lo);
        int   cyc;
        logic done;
        logic ready_bad;
        cyc       = 0;
        done      = 1'b0;
        ready_bad = 1'b0;
        @(negedge clk);
        apply_stimulus(op, a, b);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) in_valid = 1'b0;
            if (out_valid) done = 1'b1;
            else if (in_ready) ready_bad = 1'b1;
        end
        check_val({name, " completed"}, W'(done), W'(1'b1));
        check_val({name, " latency"}, W'(cyc), W'(W + 2));
        check_val({name, " in_ready low while busy"}, W'(ready_bad), W'(1'b0));
        check_val({name, " in_ready after"}, W'(in_ready), W'(1'b1));
        check_val({name, " alu_out"}, alu_out, exp_lo);
        check_val({name, " hi"}, hi_out, exp_hi);
        check_val({name, " lo"}, lo_out, exp_lo);
        check_val({name, " zero"}, W'(zero), W'(exp_lo == '0));
    endtask

    initial begin
        int pulses;
        logic early;

        vecs[0] = '{OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{OP_OR,   32'hF000_0001, 32'h0000_0100, 32'hF000_0101, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{4'b0011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        alu_op   = OP_AND;
        A        = '0;
        B        = '0;
        repeat (2) @(negedge clk);
        check_val("reset out_valid", W'(out_valid), W'(1'b0));
        check_val("reset alu_out", alu_out, '0);
        check_val("reset zero", W'(zero), W'(1'b1));
        check_val("reset carry", W'(carry_out), W'(1'b0));
        check_val("reset overflow", W'(overflow), W'(1'b0));
        check_val("reset hi", hi_out, '0);
        check_val("reset lo", lo_out, '0);
        check_val("reset in_ready", W'(in_ready), W'(1'b1));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            check_output($sformatf("vec%0d", i), vecs[i].exp_out,
                         vecs[i].exp_carry, vecs[i].exp_ovf, vecs[i].exp_zero);
        end
        in_valid = 1'b0;

        run_muldiv("MULT -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_muldiv("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_muldiv("DIVU 7/0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_muldiv("DIV -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_muldiv("DIV MIN/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_muldiv("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // MFHI issued in the completion cycle must see the freshly written HI
        apply_stimulus(OP_MFHI, '0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        check_output("MFHI at completion", 32'd2, 1'b0, 1'b0, 1'b0);

        run_muldiv("MULTU max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        apply_stimulus(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        @(negedge clk);
        check_output("b2b AND", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        apply_stimulus(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        @(negedge clk);
        check_output("b2b OR", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(OP_MFLO, '0, '0);
        @(negedge clk);
        check_output("b2b MFLO", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        apply_stimulus(OP_MFHI, '0, '0);
        @(negedge clk);
        check_output("b2b MFHI", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;

        // ADD held through BUSY: must execute exactly once, right after MULTU
        @(negedge clk);
        apply_stimulus(OP_MULTU, 32'd3, 32'd4);
        pulses = 0;
        for (int cyc = 1; cyc <= W + 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) apply_stimulus(OP_ADD, 32'd10, 32'd20);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check_val("hold MULTU latency", W'(cyc), W'(W + 2));
                    check_val("hold MULTU result", alu_out, 32'd12);
                end else if (pulses == 2) begin
                    check_val("hold ADD latency", W'(cyc), W'(W + 3));
                    check_val("hold ADD result", alu_out, 32'd30);
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check_val("hold pulse count", W'(pulses), W'(2));

        // Reset ten cycles into a MULT aborts it without touching HI/LO
        @(negedge clk);
        apply_stimulus(OP_MULT, 32'd7, 32'd9);
        early = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            if (out_valid) early = 1'b1;
            if (cyc == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_val("abort no early out_valid", W'(early), W'(1'b0));
        check_val("abort out_valid", W'(out_valid), W'(1'b0));
        check_val("abort hi", hi_out, '0);
        check_val("abort lo", lo_out, '0);
        check_val("abort in_ready", W'(in_ready), W'(1'b1));
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check_val("abort no late out_valid", W'(pulses), W'(0));
        check_val("abort hi later", hi_out, '0);
        check_val("abort lo later", lo_out, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
